// File: rtl/data_sram_resp_if.sv
// Data-SRAM port bundle between the EX/MEM stages (master) and the memory (slave).
interface data_sram_resp_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        rdata_valid;
   logic        stall_req;
   logic        addr_err;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata,
      input  rdata_valid,
      input  stall_req,
      input  addr_err
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata,
      output rdata_valid,
      output stall_req,
      output addr_err
   );
endinterface

// File: rtl/data_sram_resp.sv
// Data memory responder: byte-lane writes in one cycle, reads after LATENCY cycles.
module data_sram_resp #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input logic           clk,
   input logic           rst,
   data_sram_resp_if.slave bus
);
   localparam int  CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam bit  MULTI = (LATENCY > 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [ADDR_W-1:0]   lat_idx;
   logic                lat_oor;
   logic [31:0]         mem [2**ADDR_W];

   logic [ADDR_W-1:0]   idx;
   logic                oor;
   logic                is_rd;
   logic                is_wr;
   logic                unused_addr;

   assign idx         = bus.data_sram_addr[ADDR_W+1:2];
   assign oor         = |bus.data_sram_addr[31:ADDR_W+2];
   assign unused_addr = ^bus.data_sram_addr[1:0];
   assign is_rd       = (state == IDLE) && bus.data_sram_en
                        && (bus.data_sram_wen == 4'b0000);
   assign is_wr       = (state == IDLE) && bus.data_sram_en
                        && (bus.data_sram_wen != 4'b0000);

   assign bus.stall_req = (is_rd && MULTI)
                          || (state == BUSY && cnt != CW'(1));

   // Array deliberately has no reset so contents survive a core reset.
   always_ff @(posedge clk) begin
      if (is_wr && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i])
               mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         lat_idx             <= '0;
         lat_oor             <= 1'b0;
         bus.data_sram_rdata <= '0;
         bus.rdata_valid     <= 1'b0;
         bus.addr_err        <= 1'b0;
      end else begin
         bus.rdata_valid <= 1'b0;
         bus.addr_err    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (is_wr) begin
                  bus.addr_err <= oor;
               end else if (is_rd) begin
                  if (LATENCY == 1) begin
                     bus.data_sram_rdata <= oor ? '0 : mem[idx];
                     bus.rdata_valid     <= 1'b1;
                     bus.addr_err        <= oor;
                  end else begin
                     state   <= BUSY;
                     cnt     <= CW'(LATENCY - 1);
                     lat_idx <= idx;
                     lat_oor <= oor;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.data_sram_rdata <= lat_oor ? '0 : mem[lat_idx];
                  bus.rdata_valid     <= 1'b1;
                  bus.addr_err        <= lat_oor;
                  state               <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
